// File: rtl/acc_rob_adapter.sv
// rtl/acc_rob_adapter.sv - multi-outstanding offload adapter with in-order response reorder buffer
module acc_rob_adapter #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumRs     = 3,
  parameter int unsigned Depth     = 4,
  localparam int unsigned IdWidth  = $clog2(Depth)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [DataWidth-1:0]       hart_id_i,
  input  logic                       x_q_valid_i,
  output logic                       x_q_ready_o,
  input  logic [31:0]                x_instr_i,
  input  logic [NumRs*DataWidth-1:0] x_rs_i,
  input  logic [NumRs-1:0]           x_rs_valid_i,
  input  logic                       x_rd_clean_i,
  input  logic                       prd_accept_i,
  input  logic [NumRs-1:0]           prd_use_rs_i,
  input  logic                       prd_writeback_i,
  output logic                       x_accept_o,
  output logic                       x_writeback_o,
  output logic                       c_q_valid_o,
  input  logic                       c_q_ready_i,
  output logic [31:0]                c_q_instr_o,
  output logic [NumRs*DataWidth-1:0] c_q_rs_o,
  output logic [IdWidth-1:0]         c_q_id_o,
  output logic [DataWidth-1:0]       c_q_hart_id_o,
  input  logic                       c_p_valid_i,
  output logic                       c_p_ready_o,
  input  logic [IdWidth-1:0]         c_p_id_i,
  input  logic [DataWidth-1:0]       c_p_data_i,
  input  logic [4:0]                 c_p_rd_i,
  input  logic                       c_p_error_i,
  output logic                       x_p_valid_o,
  input  logic                       x_p_ready_i,
  output logic [DataWidth-1:0]       x_p_data_o,
  output logic [4:0]                 x_p_rd_o,
  output logic                       x_p_error_o,
  output logic [IdWidth:0]           outstanding_o
);

  localparam logic [1:0] ST_FREE   = 2'd0;
  localparam logic [1:0] ST_ISSUED = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]           state_q [Depth];
  logic [DataWidth-1:0] data_q  [Depth];
  logic [4:0]           rd_q    [Depth];
  logic                 err_q   [Depth];
  logic [IdWidth:0]     head_q, tail_q;

  logic [IdWidth-1:0] head_idx, tail_idx;
  logic full, src_ok, wb_ok, alloc, capture, retire;

  assign head_idx = head_q[IdWidth-1:0];
  assign tail_idx = tail_q[IdWidth-1:0];
  // MSB differs and index bits match: tail has lapped head by exactly Depth
  assign full     = (head_q ^ tail_q) == {1'b1, {IdWidth{1'b0}}};

  // Every used source operand must be available before offloading
  always_comb begin
    src_ok = 1'b1;
    for (int j = 0; j < NumRs; j++) begin
      src_ok = src_ok & (~prd_use_rs_i[j] | x_rs_valid_i[j]);
    end
  end

  assign x_accept_o    = prd_accept_i;
  assign x_writeback_o = prd_accept_i & prd_writeback_i;
  assign wb_ok         = ~x_writeback_o | x_rd_clean_i;

  assign c_q_valid_o   = x_q_valid_i & prd_accept_i & src_ok & wb_ok & ~full;
  assign x_q_ready_o   = ~prd_accept_i | (src_ok & wb_ok & ~full & c_q_ready_i);
  assign c_q_instr_o   = x_instr_i;
  assign c_q_id_o      = tail_idx;
  assign c_q_hart_id_o = hart_id_i;
  assign c_p_ready_o   = 1'b1;

  // Operands the instruction does not use are forwarded as zero
  always_comb begin
    c_q_rs_o = '0;
    for (int j = 0; j < NumRs; j++) begin
      c_q_rs_o[j*DataWidth +: DataWidth] = prd_use_rs_i[j] ? x_rs_i[j*DataWidth +: DataWidth] : '0;
    end
  end

  // Stale tags (e.g. responses still in flight across a reset) are ignored
  assign alloc   = c_q_valid_o & c_q_ready_i;
  assign capture = c_p_valid_i & (state_q[c_p_id_i] == ST_ISSUED);
  assign retire  = x_p_valid_o & x_p_ready_i;

  assign x_p_valid_o   = state_q[head_idx] == ST_DONE;
  assign x_p_data_o    = data_q[head_idx];
  assign x_p_rd_o      = rd_q[head_idx];
  assign x_p_error_o   = err_q[head_idx];
  assign outstanding_o = tail_q - head_q;

  // Entry lifecycle and pointers; allocate, capture and retire touch distinct entries
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) state_q[i] <= ST_FREE;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (alloc) begin
        state_q[tail_idx] <= ST_ISSUED;
        tail_q            <= tail_q + 1'b1;
      end
      if (capture) state_q[c_p_id_i] <= ST_DONE;
      if (retire) begin
        state_q[head_idx] <= ST_FREE;
        head_q            <= head_q + 1'b1;
      end
    end
  end

  // Result payload; only meaningful while the matching entry is DONE
  always_ff @(posedge clk_i) begin
    if (capture) begin
      data_q[c_p_id_i] <= c_p_data_i;
      rd_q[c_p_id_i]   <= c_p_rd_i;
      err_q[c_p_id_i]  <= c_p_error_i;
    end
  end

`ifndef SYNTHESIS
  a_resp_tag_issued: assert property (@(posedge clk_i) disable iff (rst_i)
    c_p_valid_i |-> state_q[c_p_id_i] == ST_ISSUED);
  a_xp_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (x_p_valid_o & ~x_p_ready_i) |=> (x_p_valid_o && $stable(x_p_data_o) && $stable(x_p_rd_o) && $stable(x_p_error_o)));
  a_xq_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (x_q_valid_i & ~x_q_ready_o) |=> x_q_valid_i);
`endif

endmodule
